pipe_ctrl: RTL and testbench

//  Pipeline control unit for the RV32I 5-stage core. Takes branch/jump

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the RV32I pipeline and its control unit.
// The pipeline side (master) drives the resolution and hazard requests;
// the control unit (slave) returns redirect, stall, flush and status.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             jump_en_i;
  logic [31:0]      jump_addr_i;
  logic             hold_ex_i;
  logic             load_use_i;
  logic             bus_hold_i;
  logic             jump_en_o;
  logic [31:0]      jump_addr_o;
  logic [3:0]       stall_o;
  logic [1:0]       flush_o;
  logic             hold_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] redir_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_ex_i, load_use_i, bus_hold_i,
    input  jump_en_o, jump_addr_o, stall_o, flush_o, hold_timeout_o,
           stall_cnt_o, redir_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_ex_i, load_use_i, bus_hold_i,
    output jump_en_o, jump_addr_o, stall_o, flush_o, hold_timeout_o,
           stall_cnt_o, redir_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the RV32I 5-stage core.
// Sequences PC redirect (one cycle after EX resolves a taken jump),
// per-stage stalls and bubble insertion, watches multi-cycle EX holds
// for runaway operations and counts stall cycles and redirects.
// stall_o: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM   flush_o: [0]IF/ID [1]ID/EX
module pipe_ctrl #(
  parameter int HOLD_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int HC_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      redir_addr_q, redir_addr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic             jump_en_c;
  logic [31:0]      jump_addr_c;
  logic [3:0]       stall_c;
  logic [1:0]       flush_c;
  logic             run_eval_c;

  // Next-state and combinational pipeline controls from state + requests.
  // RUN-style evaluation is shared so that a HOLD_EX release behaves
  // exactly like RUN in the same cycle.
  always_comb begin
    state_d      = state_q;
    redir_addr_d = redir_addr_q;
    hold_cnt_d   = hold_cnt_q;
    jump_en_c    = 1'b0;
    jump_addr_c  = 32'd0;
    stall_c      = 4'b0000;
    flush_c      = 2'b00;
    run_eval_c   = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_eval_c = 1'b1;
      end
      ST_REDIR: begin
        if (bus.bus_hold_i) begin
          // Keep the pending redirect until the bus frees up.
          stall_c = 4'b1111;
        end else begin
          jump_en_c   = 1'b1;
          jump_addr_c = redir_addr_q;
          flush_c     = 2'b01;
          state_d     = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (bus.bus_hold_i) begin
          stall_c = 4'b1111;
        end else if (bus.hold_ex_i) begin
          stall_c = 4'b0111;
          if (hold_cnt_q != {HC_W{1'b1}}) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end else begin
          hold_cnt_d = '0;
          run_eval_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_eval_c) begin
      if (bus.bus_hold_i) begin
        stall_c = 4'b1111;
        state_d = ST_RUN;
      end else if (bus.hold_ex_i) begin
        // First hold cycle counts toward the watchdog.
        stall_c    = 4'b0111;
        hold_cnt_d = HC_W'(1);
        state_d    = ST_HOLD;
      end else if (bus.jump_en_i) begin
        flush_c      = 2'b11;
        redir_addr_d = bus.jump_addr_i;
        state_d      = ST_REDIR;
      end else if (bus.load_use_i) begin
        stall_c = 4'b0011;
        flush_c = 2'b10;
        state_d = ST_RUN;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Sticky watchdog flag and saturating performance counters.
  always_comb begin
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (hold_cnt_d >= HC_W'(HOLD_TIMEOUT)) begin
      timeout_d = 1'b1;
    end
    if ((stall_c != 4'b0000) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (jump_en_c && (redir_cnt_q != {CNT_W{1'b1}})) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  // State register; reset discards any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      redir_addr_q <= 32'd0;
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      redir_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_addr_q <= redir_addr_d;
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      redir_cnt_q  <= redir_cnt_d;
    end
  end

  assign bus.jump_en_o      = jump_en_c;
  assign bus.jump_addr_o    = jump_addr_c;
  assign bus.stall_o        = stall_c;
  assign bus.flush_o        = flush_c;
  assign bus.hold_timeout_o = timeout_q;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.redir_cnt_o    = redir_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a vector table plus hand-written
// hold-watchdog and counter-saturation sequences, with expectations
// queued at drive time and compared when the outputs settle.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.CNT_W(4)) bus_if ();

  pipe_ctrl #(.HOLD_TIMEOUT(64), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r;
    logic        je;
    logic [31:0] ja;
    logic        hx;
    logic        lu;
    logic        bh;
    logic        eje;
    logic [31:0] eja;
    logic [3:0]  est;
    logic [1:0]  efl;
    logic        eto;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;
  int   exp_sc  = 0;
  int   exp_rc  = 0;

  function automatic vec_t mk(logic r, logic je, logic [31:0] ja, logic hx,
                              logic lu, logic bh, logic eje, logic [31:0] eja,
                              logic [3:0] est, logic [1:0] efl, logic eto);
    vec_t v;
    v.r = r; v.je = je; v.ja = ja; v.hx = hx; v.lu = lu; v.bh = bh;
    v.eje = eje; v.eja = eja; v.est = est; v.efl = efl; v.eto = eto;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after settle.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst                = v.r;
    bus_if.jump_en_i   = v.je;
    bus_if.jump_addr_i = v.ja;
    bus_if.hold_ex_i   = v.hx;
    bus_if.load_use_i  = v.lu;
    bus_if.bus_hold_i  = v.bh;
    sb_q.push_back(v);
    if (v.r) begin
      exp_sc = 0;
      exp_rc = 0;
    end
    #1;
    e = sb_q.pop_front();
    chk("jump_en",   {31'd0, bus_if.jump_en_o},      {31'd0, e.eje});
    chk("jump_addr", bus_if.jump_addr_o,             e.eja);
    chk("stall",     {28'd0, bus_if.stall_o},        {28'd0, e.est});
    chk("flush",     {30'd0, bus_if.flush_o},        {30'd0, e.efl});
    chk("timeout",   {31'd0, bus_if.hold_timeout_o}, {31'd0, e.eto});
    chk("stall_cnt", {28'd0, bus_if.stall_cnt_o},    32'(exp_sc));
    chk("redir_cnt", {28'd0, bus_if.redir_cnt_o},    32'(exp_rc));
    $display("step %0d rst=%0b je=%0b ja=%h hx=%0b lu=%0b bh=%0b -> jo=%0b jao=%h st=%b fl=%b to=%0b sc=%0d rc=%0d",
             step_no, v.r, v.je, v.ja, v.hx, v.lu, v.bh, bus_if.jump_en_o,
             bus_if.jump_addr_o, bus_if.stall_o, bus_if.flush_o,
             bus_if.hold_timeout_o, bus_if.stall_cnt_o, bus_if.redir_cnt_o);
    if (!v.r) begin
      if (e.est != 4'b0000 && exp_sc < 15) exp_sc++;
      if (e.eje && exp_rc < 15) exp_rc++;
    end
    step_no++;
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.jump_en_i   = 1'b0;
    bus_if.jump_addr_i = 32'd0;
    bus_if.hold_ex_i   = 1'b0;
    bus_if.load_use_i  = 1'b0;
    bus_if.bus_hold_i  = 1'b0;

    //                r  je  ja           hx lu bh  eje eja          est      efl    eto
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0)); // reset
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0)); // idle
    tbl.push_back(mk(0, 1, 32'h100,      0, 0, 0,  0, 32'h0,       4'b0000, 2'b11, 0)); // jump N
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 32'h100,     4'b0000, 2'b01, 0)); // redirect N+1
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 32'h0,       4'b0011, 2'b10, 0)); // load-use
    tbl.push_back(mk(0, 1, 32'h200,      0, 1, 0,  0, 32'h0,       4'b0000, 2'b11, 0)); // jump beats load-use
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 32'h200,     4'b0000, 2'b01, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 1, 32'h300,      0, 0, 0,  0, 32'h0,       4'b0000, 2'b11, 0)); // jump then bus hold
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 32'h0,       4'b1111, 2'b00, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 32'h0,       4'b1111, 2'b00, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 32'h0,       4'b1111, 2'b00, 0));
    tbl.push_back(mk(0, 1, 32'h999,      0, 0, 0,  1, 32'h300,     4'b0000, 2'b01, 0)); // held redirect; new jump ignored
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 1, 32'h400,      0, 0, 1,  0, 32'h0,       4'b1111, 2'b00, 0)); // bus hold beats jump
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 1, 32'h500,      1, 0, 0,  0, 32'h0,       4'b0111, 2'b00, 0)); // hold_ex beats jump
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0, 32'h0,       4'b0111, 2'b00, 0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 1,  0, 32'h0,       4'b1111, 2'b00, 0)); // bus hold in HOLD_EX
    tbl.push_back(mk(0, 1, 32'h600,      0, 0, 0,  0, 32'h0,       4'b0000, 2'b11, 0)); // hold falls with jump
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 32'h600,     4'b0000, 2'b01, 0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0, 32'h0,       4'b0111, 2'b00, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 32'h0,       4'b0011, 2'b10, 0)); // hold falls with load-use
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 1, 32'h700,      0, 0, 0,  0, 32'h0,       4'b0000, 2'b11, 0)); // jump then reset
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0)); // rst while in REDIR
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0)); // redirect discarded
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 32'h0,       4'b0000, 2'b00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Watchdog: 64 consecutive hold cycles, flag visible after the 64th.
    for (int i = 0; i < 64; i++) begin
      apply(mk(0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 4'b0111, 2'b00, 0));
    end
    apply(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0000, 2'b00, 1));
    apply(mk(0, 1, 32'h800, 0, 0, 0, 0, 32'h0, 4'b0000, 2'b11, 1));
    apply(mk(0, 0, 32'h0, 0, 0, 0, 1, 32'h800, 4'b0000, 2'b01, 1));
    apply(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0000, 2'b00, 0));  // only rst clears it

    // Counter saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 2'b00, 0));
    end
    apply(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0000, 2'b00, 0));
    chk("stall_cnt_sat", {28'd0, bus_if.stall_cnt_o}, 32'h0000_000F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
